// File: rtl/core_pkg.sv
// Shared core types: datapath width, memory-stage FSM states
// and base opcodes used by decode, execute and memory.
package core_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } mem_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: valid/ready request channel plus
// a valid-only read response channel.
interface mem_stage_if;
  import core_pkg::*;

  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_we;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req_valid,
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    input  dmem_req_ready,
    input  dmem_rsp_valid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req_valid,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    output dmem_req_ready,
    output dmem_rsp_valid,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: doubleword LD/SD over the dmem port,
// single-cycle writeback pulse, load timeout and misalign errors.
module mem_stage
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  store_data,
  input  logic             mem_we,
  input  logic             mem_to_reg,
  input  logic             rd_we,
  input  logic [4:0]       rd_addr,
  mem_stage_if.master      dmem,
  output logic             wb_valid,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_err
);

  mem_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [4:0]      rd_q;
  logic            we_q, st_q;
  logic            wbv_n, wbwe_n, wbe_n;
  logic [XLEN-1:0] wbd_n;
  logic            accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_we    = st_q;
  assign wb_rd           = rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n             = state;
    cnt_n               = cnt;
    wbv_n               = 1'b0;
    wbwe_n              = wb_we;
    wbd_n               = wb_data;
    wbe_n               = wb_err;
    dmem.dmem_req_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!mem_we && !mem_to_reg) begin
            wbv_n  = 1'b1;
            wbwe_n = rd_we;
            wbd_n  = alu_result;
            wbe_n  = 1'b0;
          end else if (alu_result[2:0] != 3'b000) begin
            wbv_n  = 1'b1;
            wbwe_n = 1'b0;
            wbd_n  = '0;
            wbe_n  = 1'b1;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        dmem.dmem_req_valid = 1'b1;
        if (dmem.dmem_req_ready) begin
          if (st_q) begin
            state_n = IDLE;
            wbv_n   = 1'b1;
            wbwe_n  = 1'b0;
            wbe_n   = 1'b0;
          end else begin
            state_n = WAIT_RSP;
            cnt_n   = '0;
          end
        end
      end
      WAIT_RSP: begin
        // a response in the timeout cycle still completes the load
        if (dmem.dmem_rsp_valid) begin
          state_n = IDLE;
          wbv_n   = 1'b1;
          wbwe_n  = we_q;
          wbd_n   = dmem.dmem_rdata;
          wbe_n   = 1'b0;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          wbv_n   = 1'b1;
          wbwe_n  = 1'b0;
          wbd_n   = '0;
          wbe_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      st_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= alu_result;
      wdata_q <= store_data;
      rd_q    <= rd_addr;
      we_q    <= rd_we;
      st_q    <= mem_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_data  <= '0;
      wb_err   <= 1'b0;
    end else begin
      wb_valid <= wbv_n;
      wb_we    <= wbwe_n;
      wb_data  <= wbd_n;
      wb_err   <= wbe_n;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard on the writeback
// port plus point checks on the handshake and memory port.
module tb_mem_stage;

  typedef struct {
    logic [63:0] data;
    logic        we;
    logic [4:0]  rd;
    logic        err;
    logic        chk_data;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] alu_result = '0;
  logic [63:0] store_data = '0;
  logic        mem_we = 1'b0;
  logic        mem_to_reg = 1'b0;
  logic        rd_we = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_err;

  int tests = 0;
  int fails = 0;
  wb_exp_t sb[$];

  mem_stage_if dmem ();

  mem_stage #(
    .TIMEOUT_CYCLES(8),
    .CNT_W(9)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_result(alu_result),
    .store_data(store_data),
    .mem_we(mem_we),
    .mem_to_reg(mem_to_reg),
    .rd_we(rd_we),
    .rd_addr(rd_addr),
    .dmem(dmem.master),
    .wb_valid(wb_valid),
    .wb_we(wb_we),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic we,
                      input logic [4:0] rd, input logic err,
                      input logic cd);
    wb_exp_t e;
    e.data = d;
    e.we = we;
    e.rd = rd;
    e.err = err;
    e.chk_data = cd;
    sb.push_back(e);
  endtask

  task automatic drive_op(input logic [63:0] a, input logic [63:0] sd,
                          input logic st, input logic ld,
                          input logic we, input logic [4:0] rd);
    in_valid   = 1'b1;
    alu_result = a;
    store_data = sd;
    mem_we     = st;
    mem_to_reg = ld;
    rd_we      = we;
    rd_addr    = rd;
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (sb.size() == 0) begin
        tests++;
        assert (1'b0) else begin
          fails++;
          $error("FAIL wb_unexpected observed=rd%0d expected=none",
                 wb_rd);
        end
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        tests++;
        assert (wb_err === e.err && wb_we === e.we && wb_rd === e.rd)
        else begin
          fails++;
          $error("FAIL wb_ctrl observed=err%b we%b rd%0d expected=err%b we%b rd%0d",
                 wb_err, wb_we, wb_rd, e.err, e.we, e.rd);
        end
        if (e.chk_data) begin
          tests++;
          assert (wb_data === e.data) else begin
            fails++;
            $error("FAIL wb_data observed=%h expected=%h", wb_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rdata     = '0;

    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_req_valid", 64'(dmem.dmem_req_valid), 64'd0);
    chk("rst_addr", dmem.dmem_addr, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    rst_n = 1'b1;
    tick();

    // ALU passthrough, then back-to-back
    drive_op(64'h1234, 64'd0, 1'b0, 1'b0, 1'b1, 5'd5);
    push(64'h1234, 1'b1, 5'd5, 1'b0, 1'b1);
    tick();
    chk("alu_wb_valid", 64'(wb_valid), 64'd1);
    chk("alu_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drive_op(64'h1000 + 64'(i), 64'd0, 1'b0, 1'b0, i[0], 5'(i + 10));
      push(64'h1000 + 64'(i), i[0], 5'(i + 10), 1'b0, 1'b1);
      tick();
      chk("b2b_wb_valid", 64'(wb_valid), 64'd1);
    end
    idle_in();
    tick();
    chk("b2b_done", 64'(wb_valid), 64'd0);

    // aligned store with 3 cycles of backpressure
    drive_op(64'h100, 64'hDEADBEEF, 1'b1, 1'b0, 1'b1, 5'd7);
    push(64'd0, 1'b0, 5'd7, 1'b0, 1'b0);
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      chk("st_req_valid", 64'(dmem.dmem_req_valid), 64'd1);
      chk("st_addr", dmem.dmem_addr, 64'h100);
      chk("st_wdata", dmem.dmem_wdata, 64'hDEADBEEF);
      chk("st_we", 64'(dmem.dmem_we), 64'd1);
      chk("st_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready = 1'b0;
    chk("st_wb_valid", 64'(wb_valid), 64'd1);
    chk("st_wb_we", 64'(wb_we), 64'd0);
    tick();

    // aligned load, response 4 cycles after handshake
    drive_op(64'h208, 64'd0, 1'b0, 1'b1, 1'b1, 5'd9);
    dmem.dmem_req_ready = 1'b1;
    push(64'hCAFEF00D, 1'b1, 5'd9, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("ld_req_valid", 64'(dmem.dmem_req_valid), 64'd1);
    chk("ld_we", 64'(dmem.dmem_we), 64'd0);
    chk("ld_addr", dmem.dmem_addr, 64'h208);
    tick();
    dmem.dmem_req_ready = 1'b0;
    chk("ld_wait_req", 64'(dmem.dmem_req_valid), 64'd0);
    tick();
    tick();
    tick();
    chk("ld_wait_wb", 64'(wb_valid), 64'd0);
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rdata     = 64'hCAFEF00D;
    tick();
    dmem.dmem_rsp_valid = 1'b0;
    chk("ld_wb_valid", 64'(wb_valid), 64'd1);
    chk("ld_wb_data", wb_data, 64'hCAFEF00D);
    tick();

    // misaligned load
    drive_op(64'h103, 64'd0, 1'b0, 1'b1, 1'b1, 5'd3);
    push(64'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    idle_in();
    chk("mis_req_valid", 64'(dmem.dmem_req_valid), 64'd0);
    chk("mis_wb_err", 64'(wb_err), 64'd1);
    chk("mis_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("mis_req_after", 64'(dmem.dmem_req_valid), 64'd0);

    // load timeout after 8 wait cycles
    drive_op(64'h300, 64'd0, 1'b0, 1'b1, 1'b1, 5'd4);
    dmem.dmem_req_ready = 1'b1;
    push(64'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    idle_in();
    tick();
    dmem.dmem_req_ready = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("to_early_wb", 64'(wb_valid), 64'd0);
    chk("to_early_rdy", 64'(in_ready), 64'd0);
    tick();
    chk("to_wb_valid", 64'(wb_valid), 64'd1);
    chk("to_wb_err", 64'(wb_err), 64'd1);
    chk("to_in_ready", 64'(in_ready), 64'd1);
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rdata     = 64'hBAD;
    tick();
    dmem.dmem_rsp_valid = 1'b0;
    chk("late_rsp_wb", 64'(wb_valid), 64'd0);
    drive_op(64'h55, 64'd0, 1'b0, 1'b0, 1'b1, 5'd6);
    push(64'h55, 1'b1, 5'd6, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("post_to_alu", 64'(wb_valid), 64'd1);
    tick();

    // async reset while waiting for a response
    drive_op(64'h400, 64'd0, 1'b0, 1'b1, 1'b1, 5'd8);
    dmem.dmem_req_ready = 1'b1;
    tick();
    idle_in();
    tick();
    dmem.dmem_req_ready = 1'b0;
    tick();
    chk("pre_rst_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_addr", dmem.dmem_addr, 64'd0);
    chk("arst_wb_rd", 64'(wb_rd), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rdata     = 64'h777;
    tick();
    dmem.dmem_rsp_valid = 1'b0;
    chk("stray_rsp_wb", 64'(wb_valid), 64'd0);
    tick();
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
